// File: rtl/proj_sketch_reader.sv
// Sketch reader: snapshots the sorter's smallest-index vector on frame done, clears the
// sorter, then streams the first min(count, K) indices out over valid/ready.
package proj_pkg;
  localparam int unsigned HASHER_EXTENDER_INDICES_COUNT = 4;
endpackage

module proj_sketch_reader #(
  parameter int unsigned INDICES_COUNT = proj_pkg::HASHER_EXTENDER_INDICES_COUNT,
  parameter int unsigned INDEX_W       = 8,
  parameter int unsigned COUNT_W       = 16,
  localparam int unsigned SLOT_W       = $clog2(INDICES_COUNT)
) (
  input  logic                                    in_clk,
  input  logic                                    in_rst,
  input  logic [INDICES_COUNT-1:0][INDEX_W-1:0]   in_smallest_idx,
  input  logic [COUNT_W-1:0]                      in_item_count,
  input  logic                                    in_frame_done,
  output logic                                    out_sorter_clear,
  output logic                                    out_valid,
  input  logic                                    in_ready,
  output logic [INDEX_W-1:0]                      out_idx,
  output logic [SLOT_W-1:0]                       out_slot,
  output logic                                    out_last,
  output logic                                    out_busy,
  output logic                                    out_frame_empty,
  output logic                                    out_frame_drop
);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  localparam logic [COUNT_W-1:0] CountMax = COUNT_W'(INDICES_COUNT);
  localparam logic [SLOT_W:0]    NMax     = (SLOT_W+1)'(INDICES_COUNT);
  localparam logic [SLOT_W:0]    NOne     = (SLOT_W+1)'(1);
  localparam logic [SLOT_W-1:0]  SlotOne  = SLOT_W'(1);

  state_e                                state_q, state_d;
  logic [INDICES_COUNT-1:0][INDEX_W-1:0] snap_q, snap_d;
  logic [SLOT_W:0]                       cnt_q, cnt_d;
  logic [SLOT_W-1:0]                     slot_q, slot_d;
  logic [INDEX_W-1:0]                    idx_q, idx_d;
  logic                                  valid_q, valid_d;
  logic                                  last_q, last_d;
  logic                                  clear_q, clear_d;
  logic                                  empty_q, empty_d;
  logic                                  drop_q, drop_d;

  logic              fire, last_fire, accept;
  logic [SLOT_W:0]   n_in;
  logic [SLOT_W-1:0] slot_nxt;

  assign fire      = valid_q & in_ready;
  assign last_fire = fire & last_q;
  // A new frame may land on the same edge as the previous frame's final beat.
  assign accept    = in_frame_done & ((state_q == StIdle) | last_fire);
  assign n_in      = (in_item_count >= CountMax) ? NMax : in_item_count[SLOT_W:0];
  assign slot_nxt  = slot_q + SlotOne;

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    cnt_d   = cnt_q;
    slot_d  = slot_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    last_d  = last_q;
    clear_d = accept;
    empty_d = 1'b0;
    drop_d  = in_frame_done & (state_q == StSend) & ~last_fire;

    if (accept) begin
      snap_d = in_smallest_idx;
      cnt_d  = n_in;
      slot_d = '0;
      if (n_in != '0) begin
        state_d = StSend;
        valid_d = 1'b1;
        idx_d   = in_smallest_idx[0];
        last_d  = (n_in == NOne);
      end else begin
        state_d = StIdle;
        valid_d = 1'b0;
        last_d  = 1'b0;
        empty_d = 1'b1;
      end
    end else if (last_fire) begin
      state_d = StIdle;
      valid_d = 1'b0;
      last_d  = 1'b0;
    end else if (fire) begin
      slot_d = slot_nxt;
      idx_d  = snap_q[slot_nxt];
      last_d = ({1'b0, slot_nxt} == (cnt_q - NOne));
    end
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state_q <= StIdle;
      snap_q  <= '0;
      cnt_q   <= '0;
      slot_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      clear_q <= 1'b0;
      empty_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      cnt_q   <= cnt_d;
      slot_q  <= slot_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      clear_q <= clear_d;
      empty_q <= empty_d;
      drop_q  <= drop_d;
    end
  end

  assign out_valid        = valid_q;
  assign out_idx          = idx_q;
  assign out_slot         = slot_q;
  assign out_last         = last_q;
  assign out_busy         = (state_q == StSend);
  assign out_sorter_clear = clear_q;
  assign out_frame_empty  = empty_q;
  assign out_frame_drop   = drop_q;

endmodule
